// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - handshake and operand/result bundle for serial_subtractor
// Ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_bin;
    logic             o_ready;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_diff;
    logic             o_bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             o_ovf;

    modport master (output i_start, i_a, i_b, i_bin,
                    input  o_ready, o_busy, o_done, o_diff, o_bout, o_ovf);
    modport slave  (input  i_start, i_a, i_b, i_bin,
                    output o_ready, o_busy, o_done, o_diff, o_bout, o_ovf);
`else
    modport master (output i_start, i_a, i_b, i_bin,
                    input  o_ready, o_busy, o_done, o_diff, o_bout);
    modport slave  (input  i_start, i_a, i_b, i_bin,
                    output o_ready, o_busy, o_done, o_diff, o_bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - Bin, one full-subtractor slice per clock, LSB first
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    serial_subtractor_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_res;
    logic             r_w;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_ovf;
`endif

    logic             w_a;
    logic             w_b;
    logic             w_d;
    logic             w_w_next;
    logic             w_last;
    logic [WIDTH-1:0] w_res_full;

    assign w_a        = r_a_sh[0];
    assign w_b        = r_b_sh[0];
    assign w_d        = w_a ^ w_b ^ r_w;
    assign w_w_next   = (~w_a & w_b) | (~w_a & r_w) | (w_b & r_w);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    // Completed result on the last slice: newest bit on top of the partial bits.
    assign w_res_full = {w_d, r_res};

    assign bus.o_ready = r_ready;
    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;
    assign bus.o_diff  = r_diff;
    assign bus.o_bout  = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.o_ovf   = r_ovf;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_w     <= 1'b0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.i_start) begin
                        r_a_sh  <= bus.i_a;
                        r_b_sh  <= bus.i_b;
                        r_w     <= bus.i_bin;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_res  <= w_res_full[WIDTH-1:1];
                    r_w    <= w_w_next;
                    r_cnt  <= r_cnt + 1'b1;
                    // Results are published only here so they never show partial values.
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_diff  <= w_res_full;
                        r_bout  <= w_w_next;
`ifdef SERIAL_SUB_OVF_EN
                        r_ovf   <= r_w ^ w_w_next;
`endif
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - vector table plus scoreboard bench for serial_subtractor
// Checks Ovf as well when built with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;
    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH + 1;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();
    serial_subtractor #(.WIDTH(WIDTH)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int         total = 0;
    int         bad   = 0;
    vec_t       sb[$];
    vec_t       vecs[10];
    logic [7:0] prev_diff;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
        vec_t       v;
        logic [8:0] t;
        t      = {1'b0, a} - {1'b0, b} - {8'b0, bin};
        v.a    = a;
        v.b    = b;
        v.bin  = bin;
        v.diff = t[7:0];
        v.bout = t[8];
        v.ovf  = (a[7] ^ b[7]) & (t[7] ^ a[7]);
        return v;
    endfunction

    // Caller is at a negedge; drives a request for the next rising edge.
    task automatic launch(input vec_t v);
        bus.i_start = 1'b1;
        bus.i_a     = v.a;
        bus.i_b     = v.b;
        bus.i_bin   = v.bin;
        sb.push_back(v);
    endtask

    task automatic compare_result();
        vec_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        check("diff", bus.o_diff, e.diff);
        check("bout", bus.o_bout, e.bout);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", bus.o_ovf, e.ovf);
`endif
        prev_diff = e.diff;
    endtask

    // mode 0: plain; mode 1: Start pulses with other operands while busy.
    task automatic finish_op(input int mode);
        int n;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        bus.i_start = 1'b0;
        while (!bus.o_done && n < 40) begin
            if (mode == 1) begin
                bus.i_start = (n == 2 || n == 5);
                bus.i_a     = 8'hFF;
                bus.i_b     = 8'h01;
                bus.i_bin   = 1'b1;
                if (n == 4) begin
                    check("busy_in_run", bus.o_busy, 1);
                    check("ready_in_run", bus.o_ready, 0);
                    check("diff_hold", bus.o_diff, prev_diff);
                end
            end
            @(posedge clk);
            n++;
            @(negedge clk);
            bus.i_start = 1'b0;
        end
        check("latency", n, LAT);
        check("ready_at_done", bus.o_ready, 1);
        check("busy_at_done", bus.o_busy, 0);
        compare_result();
    endtask

    task automatic do_op(input vec_t v, input int mode);
        @(negedge clk);
        launch(v);
        finish_op(mode);
    endtask

    initial begin
        vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1};
        vecs[8] = '{8'h55, 8'hAA, 1'b0, 8'hAB, 1'b1, 1'b1};
        vecs[9] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};

        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_bin   = 1'b0;
        prev_diff   = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", bus.o_ready, 1);
        check("rst_busy", bus.o_busy, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_diff", bus.o_diff, 0);
        check("rst_bout", bus.o_bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", bus.o_ovf, 0);
`endif
        // Start together with reset: reset must win.
        bus.i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_start_busy", bus.o_busy, 0);
        check("rst_start_ready", bus.o_ready, 1);
        bus.i_start = 1'b0;
        rst         = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i], 0);
            @(negedge clk);
            check("done_one_cycle", bus.o_done, 0);
        end

        for (int i = 0; i < 16; i++) begin
            do_op(model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                        1'($urandom_range(0, 1))), 0);
        end

        // Start pulses while busy must not disturb the running operation.
        do_op(vecs[0], 1);

        // Reset at RUN cycle 4 aborts the operation.
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_a     = 8'h80;
        bus.i_b     = 8'h01;
        bus.i_bin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", bus.o_ready, 1);
        check("abort_busy", bus.o_busy, 0);
        check("abort_done", bus.o_done, 0);
        check("abort_diff", bus.o_diff, 0);
        check("abort_bout", bus.o_bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("abort_ovf", bus.o_ovf, 0);
`endif
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (bus.o_done) seen++;
            end
            check("abort_no_done", seen, 0);
        end
        prev_diff = 8'h00;
        do_op(vecs[3], 0);

        // Back-to-back: new request in the DONE cycle.
        do_op(vecs[7], 0);
        launch(vecs[8]);
        finish_op(0);

        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
